key_debounce: RTL
=================

// Module: key_debounce
//
// PURPOSE
// - Front end for the push-button KEY inputs, ahead of oneshot (the edge-to-pulse stage).
// - Each raw active-low key passes through a 2-flop synchronizer, then a per-key
//   stability counter.
// - Output is a clean, glitch-free active-low level per key (0 = pressed, 1 = released).
// - oneshot samples this output directly on the same clk.
//
// PARAMETERS
// - NUM_KEYS         default 4       number of independent key channels
// - DEBOUNCE_CYCLES  default 500000  consecutive clk edges a new level must persist
//                                    (10 ms at 50 MHz); legal range >= 2
// - CNT_W            default $clog2(DEBOUNCE_CYCLES+1)  counter width; derived, do not override
//
// PORTS
// - clk          input   1         system clock, all logic on posedge
// - reset        input   1         asynchronous, active-high reset
// - key_raw      input   NUM_KEYS  raw board keys, active-low, asynchronous to clk
// - key_db       output  NUM_KEYS  debounced level, active-low; feeds oneshot edge_sig
// - key_changed  output  NUM_KEYS  1-cycle strobe on the edge where key_db[i] toggles
//
// BEHAVIOUR
// Reset (asynchronous)
// - sync flops <= '1; key_db <= '1 (all released); key_changed <= '0.
// - Every counter <= 0; every channel state <= ST_STABLE.
//
// Synchronizer
// - key_sync[i] = key_raw[i] after 2 flops. No logic between the two flops.
//
// Per-channel FSM (channels fully independent)
// - ST_STABLE: if key_sync != key_db -> ST_CHECK, cnt <= 1; else hold, cnt <= 0.
// - ST_CHECK, key_sync == key_db: bounce rejected.
//   -> ST_STABLE, cnt <= 0, key_db unchanged, no strobe.
// - ST_CHECK, key_sync != key_db, cnt == DEBOUNCE_CYCLES-1:
//   key_db <= key_sync, key_changed <= 1, -> ST_STABLE, cnt <= 0.
// - ST_CHECK, key_sync != key_db, otherwise: cnt <= cnt + 1.
// - key_changed is registered. It is high exactly the one cycle key_db shows its new
//   value, and 0 in all other cycles.
//
// Latency
// - key_db toggles on the (DEBOUNCE_CYCLES+1)th posedge after the edge that first
//   samples the new raw level, provided the level holds for that whole window.
//
// Boundaries
// - Any reversion during ST_CHECK, even for 1 cycle, restarts the count from zero on the
//   next differing sample. Pulses shorter than DEBOUNCE_CYCLES never reach key_db.
// - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
// - Simultaneous activity on several keys is handled per channel, with no interaction.
// - Reset asserted mid-count aborts the count. key_db returns to '1 immediately,
//   without waiting for clk.
// - Key held at reset release: key_db stays 1 for DEBOUNCE_CYCLES+1 edges, then
//   falls to 0.
// - The downstream oneshot reacts to the press (1->0) only. key_changed covers both
//   directions.
//
// STRUCTURE
// - Package debounce_pkg holds:
//   - typedef enum logic {ST_STABLE, ST_CHECK} db_state_t
//   - function automatic int db_cnt_w(int cycles)
// - Sub-module key_debounce_cell: synchronizer + FSM + counter for one key.
//   It is instantiated NUM_KEYS times by a generate loop.
// - The top level only packs the vectors.
//
// TESTING (bench with DEBOUNCE_CYCLES=8, NUM_KEYS=4)
// - Reset: assert reset with clk stopped -> key_db=4'b1111, key_changed=4'b0000
//   immediately.
// - Clean press: key_raw[0] 1->0 and held -> key_db[0]=0 on the 9th posedge,
//   key_changed[0]=1 for that 1 cycle only.
// - Bounce: key_raw[1] low for 5 cycles, high 1 cycle, low held -> key_db[1] falls
//   9 edges after the final fall. No strobe earlier.
// - Glitch: key_raw[2] low for 7 cycles then high -> key_db[2] stays 1,
//   key_changed[2] never asserts.
// - Release and concurrency: keys 0 and 3 released on the same edge -> both key_db bits
//   rise on the same edge, with both strobes on that cycle.
// - Mid-count reset: reset pulse 4 cycles into a press -> key_db=1, and the count
//   restarts from 0 after release. Also check the chain into oneshot: level_sig gives
//   exactly one 1-cycle pulse per debounced press.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button debounce front end.
package debounce_pkg;

  typedef enum logic {ST_STABLE, ST_CHECK} db_state_t;

  // Counter width able to hold 0 .. cycles.
  function automatic int db_cnt_w(int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: 2-flop synchronizer followed by a stability counter FSM
// that only lets a new level through after it has held for DEBOUNCE_CYCLES samples.
module key_debounce_cell
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = db_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_db,
  output logic key_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             key_db_reg;
  logic             key_changed_reg;
  logic [CNT_W-1:0] cnt_reg;
  db_state_t        state_reg;

  logic key_sync;
  assign key_sync = sync2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg       <= 1'b1;
      sync2_reg       <= 1'b1;
      key_db_reg      <= 1'b1;
      key_changed_reg <= 1'b0;
      cnt_reg         <= '0;
      state_reg       <= ST_STABLE;
    end else begin
      sync1_reg       <= key_raw;
      sync2_reg       <= sync1_reg;
      key_changed_reg <= 1'b0;
      case (state_reg)
        ST_STABLE: begin
          if (key_sync != key_db_reg) begin
            state_reg <= ST_CHECK;
            cnt_reg   <= CNT_W'(1);
          end else begin
            cnt_reg <= '0;
          end
        end
        ST_CHECK: begin
          if (key_sync == key_db_reg) begin
            // Bounce back to the accepted level: drop the partial count.
            state_reg <= ST_STABLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            key_db_reg      <= key_sync;
            key_changed_reg <= 1'b1;
            state_reg       <= ST_STABLE;
            cnt_reg         <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_STABLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign key_db      = key_db_reg;
  assign key_changed = key_changed_reg;

endmodule

// File: rtl/key_debounce.sv
// Debounced, active-low KEY front end: one independent cell per key,
// the top only packs the per-key results into vectors.
module key_debounce
  import debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = db_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_db,
  output logic [NUM_KEYS-1:0] key_changed
);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_cell (
        .clk        (clk),
        .reset      (reset),
        .key_raw    (key_raw[gi]),
        .key_db     (key_db[gi]),
        .key_changed(key_changed[gi])
      );
    end
  endgenerate

endmodule
